// File: rtl/period_meter.sv
// period_meter: cycles between successive rising edges of a pulse stream.
// Define PERIOD_METER_COMPARE_EN to build the Expected comparator (o_Match).
module period_meter #(
  parameter int Bits       = 16,
  parameter int SyncStages = 2,
  parameter int Expected   = 10
) (
  input  logic            i_Clock,
  input  logic            i_Reset_n,
  input  logic            i_Pulse,
  input  logic            i_Enable,
  input  logic            i_Ack,
  output logic [Bits-1:0] o_Period,
  output logic            o_Valid,
  output logic            o_Overflow,
  output logic            o_Overrun,
  output logic            o_Match
);

  localparam logic [Bits-1:0] MaxCnt = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic [Bits-1:0]       cnt_q, cnt_d;
  logic [Bits-1:0]       period_q, period_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  ovr_q, ovr_d;
  logic                  pulse_edge;
  logic                  load;

  assign pulse_edge = sync_q[SyncStages-1] & ~prev_q;
  assign load       = i_Enable & (state_q == COUNT) & pulse_edge;

  // Synchronizer shift and edge-detect history.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], i_Pulse};
    prev_d = sync_q[SyncStages-1];
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state: disable always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!i_Enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   state_d = pulse_edge ? COUNT : ARMED;
        COUNT:   state_d = COUNT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter: restarts at 1 on each edge, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_Enable) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE:    cnt_d = '0;
        ARMED:   cnt_d = pulse_edge ? Bits'(1) : cnt_q;
        COUNT: begin
          if (pulse_edge)           cnt_d = Bits'(1);
          else if (cnt_q != MaxCnt) cnt_d = cnt_q + Bits'(1);
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Result registers and valid/ack/overrun bookkeeping.
  always_comb begin
    period_d = load ? cnt_q : period_q;
    ovf_d    = load ? (cnt_q == MaxCnt) : ovf_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (!i_Enable) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      if (valid_q && !i_Ack) ovr_d = 1'b1;
    end else if (i_Ack) begin
      valid_d = 1'b0;
    end
  end

  assign o_Period   = period_q;
  assign o_Valid    = valid_q;
  assign o_Overflow = ovf_q;
  assign o_Overrun  = ovr_q;

`ifdef PERIOD_METER_COMPARE_EN
  logic match_q, match_d;

  // Match flag rides with the result and clears with o_Valid.
  always_comb begin
    match_d = match_q;
    if (!i_Enable) begin
      match_d = 1'b0;
    end else if (load) begin
      match_d = (cnt_q == Bits'(Expected)) && (cnt_q != MaxCnt);
    end else if (i_Ack) begin
      match_d = 1'b0;
    end
  end

  // Match register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) match_q <= 1'b0;
    else            match_q <= match_d;
  end

  assign o_Match = match_q;
`else
  // Expected is referenced only so both builds share one parameter list.
  assign o_Match = 1'b0 && (Expected < 0);
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed stimulus vs a timestamp model.
// Runs a 16-bit and a 4-bit meter side by side on shared inputs.
module tb_period_meter;

  localparam int SYNC = 2;
  localparam int EXPV = 10;
`ifdef PERIOD_METER_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse = 1'b0;
  logic en = 1'b0;
  logic ack = 1'b0;

  logic [15:0] p16;
  logic        v16, f16, r16, m16;
  logic [3:0]  p4;
  logic        v4, f4, r4, m4;

  int tests = 0;
  int fails = 0;
  int ack_mode = 0;

  always #5 clk = ~clk;

  period_meter #(.Bits(16), .SyncStages(SYNC), .Expected(EXPV)) u16 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Pulse(pulse),
    .i_Enable(en), .i_Ack(ack), .o_Period(p16), .o_Valid(v16),
    .o_Overflow(f16), .o_Overrun(r16), .o_Match(m16)
  );

  period_meter #(.Bits(4), .SyncStages(SYNC), .Expected(EXPV)) u4 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Pulse(pulse),
    .i_Enable(en), .i_Ack(ack), .o_Period(p4), .o_Valid(v4),
    .o_Overflow(f4), .o_Overrun(r4), .o_Match(m4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: rising samples of i_Pulse become edge timestamps SYNC cycles
  // later; results are timestamp differences clipped to the counter max.
  int  kcyc = 0;
  int  eq[$];
  bit  last_p = 0;
  int  st[2];
  bit  have[2];
  int  prev[2];
  int  mper[2];
  bit  mval[2], movf[2], movr[2], mmat[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq.delete();
      last_p = 0;
      for (int i = 0; i < 2; i++) begin
        st[i] = 0; have[i] = 0; prev[i] = 0; mper[i] = 0;
        mval[i] = 0; movf[i] = 0; movr[i] = 0; mmat[i] = 0;
      end
    end else begin
      bit e;
      kcyc++;
      if (pulse && !last_p) eq.push_back(kcyc + SYNC);
      last_p = pulse;
      e = 0;
      while (eq.size() > 0 && eq[0] < kcyc) void'(eq.pop_front());
      if (eq.size() > 0 && eq[0] == kcyc) begin
        e = 1;
        void'(eq.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        int mx;
        int p;
        mx = (i == 0) ? 65535 : 15;
        if (!en) begin
          st[i] = 0; have[i] = 0;
          mval[i] = 0; movr[i] = 0; mmat[i] = 0;
        end else if (st[i] == 0) begin
          st[i] = 1;
        end else if (e) begin
          if (have[i]) begin
            p = kcyc - prev[i];
            if (p > mx) p = mx;
            mper[i] = p;
            movf[i] = (p == mx);
            mmat[i] = CMP && (p == EXPV) && (p != mx);
            if (mval[i] && !ack) movr[i] = 1;
            mval[i] = 1;
          end else if (ack) begin
            mval[i] = 0; mmat[i] = 0;
          end
          have[i] = 1;
          prev[i] = kcyc;
        end else if (ack) begin
          mval[i] = 0; mmat[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of both meters against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("per16", int'(p16), mper[0]);
      chk("val16", int'(v16), int'(mval[0]));
      chk("ovf16", int'(f16), int'(movf[0]));
      chk("ovr16", int'(r16), int'(movr[0]));
      chk("mat16", int'(m16), int'(mmat[0]));
      chk("per4", int'(p4), mper[1]);
      chk("val4", int'(v4), int'(mval[1]));
      chk("ovf4", int'(f4), int'(movf[1]));
      chk("ovr4", int'(r4), int'(movr[1]));
      chk("mat4", int'(m4), int'(mmat[1]));
    end
  end

  // Ack driver: 0 = held low, 1 = one-cycle ack after valid, 2 = random.
  always @(negedge clk) begin
    if (ack_mode == 1)      ack = v16 && !ack;
    else if (ack_mode == 2) ack = ($urandom_range(0, 1) == 1);
    else                    ack = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic train(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pulse = 1'b1;
      cyc(1);
      pulse = 1'b0;
      cyc(gap - 1);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_p16"}, int'(p16), 0);
    chk({nm, "_v16"}, int'(v16), 0);
    chk({nm, "_f16"}, int'(f16), 0);
    chk({nm, "_r16"}, int'(r16), 0);
    chk({nm, "_m16"}, int'(m16), 0);
    chk({nm, "_p4"}, int'(p4), 0);
    chk({nm, "_v4"}, int'(v4), 0);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    cyc(2);
    rst_n = 1'b1;
    en = 1'b1;
    ack_mode = 1;
    cyc(3);

    // Baseline: period 10, no result after the first edge.
    train(1, 10);
    chk("first_edge_noval", int'(v16), 0);
    train(5, 10);
    chk("base_per", int'(p16), 10);
    chk("base_ovf", int'(f16), 0);
    chk("base_per4", int'(p4), 10);

    // Minimum period.
    for (int i = 0; i < 20; i++) begin
      pulse = ~pulse;
      cyc(1);
    end
    pulse = 1'b0;
    cyc(6);
    chk("min_per", int'(p16), 2);
    chk("min_mat", int'(m16), 0);

    // Overflow on the 4-bit meter, then recovery.
    train(3, 20);
    chk("ovf_per4", int'(p4), 15);
    chk("ovf_flag4", int'(f4), 1);
    chk("ovf_per16", int'(p16), 20);
    train(2, 10);
    chk("rec_per4", int'(p4), 10);
    chk("rec_flag4", int'(f4), 0);

    // Overrun with ack held low.
    ack_mode = 0;
    cyc(1);
    train(4, 7);
    chk("ovr_flag", int'(r16), 1);
    chk("ovr_val", int'(v16), 1);
    chk("ovr_per", int'(p16), 7);

    // One-cycle disable.
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_val", int'(v16), 0);
    chk("dis_ovr", int'(r16), 0);
    @(negedge clk);
    en = 1'b1;
    ack_mode = 1;
    cyc(2);

    // Reset mid-count.
    train(2, 10);
    pulse = 1'b1;
    cyc(1);
    pulse = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    train(1, 8);
    chk("rst_noval", int'(v16), 0);
    train(1, 8);
    chk("rst_per", int'(p16), 8);

    // Randomized traffic.
    ack_mode = 2;
    for (int b = 0; b < 12; b++) begin
      int dens;
      case (b % 4)
        0: dens = 50;
        1: dens = 20;
        2: dens = 6;
        default: dens = 2;
      endcase
      for (int c = 0; c < 250; c++) begin
        pulse = ($urandom_range(0, 99) < dens);
        en = ($urandom_range(0, 299) != 0);
        cyc(1);
      end
      if (b == 5) begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
    end
    en = 1'b1;
    pulse = 1'b0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
